// File: rtl/pokey_audio_ctrl.sv
// POKEY audio register front end: pending/live AUDF/AUDC/AUDCTL registers, base tick prescalers, STIMER and SKCTL mode sequencing.
// Optional readback port enabled by defining POKEY_AUDIO_CTRL_READBACK_EN.
module pokey_audio_ctrl #(
  parameter int unsigned CLK_DIV64 = 28,
  parameter int unsigned CLK_DIV15 = 114
) (
  input  logic       clk179,
  input  logic       init,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] AUDF1,
  output logic [7:0] AUDC1,
  output logic [7:0] AUDF2,
  output logic [7:0] AUDC2,
  output logic [7:0] AUDF3,
  output logic [7:0] AUDC3,
  output logic [7:0] AUDF4,
  output logic [7:0] AUDC4,
  output logic [7:0] AUDCTL,
  output logic       tick64,
  output logic       tick15,
  output logic       tick_main,
  output logic       stimer_pulse,
  output logic       poly_init_L,
  input  logic       rd_en,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int unsigned W64 = $clog2(CLK_DIV64);
  localparam int unsigned W15 = $clog2(CLK_DIV15);
  localparam logic [W64-1:0] LAST64 = W64'(CLK_DIV64 - 1);
  localparam logic [W15-1:0] LAST15 = W15'(CLK_DIV15 - 1);

  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} mode_t;

  mode_t           state, state_next;
  logic [W64-1:0]  cnt64;
  logic [W15-1:0]  cnt15;
  logic [7:0]      live [0:8];
  logic [7:0]      pend [0:8];
  logic [8:0]      pend_flag;
  logic [8:0]      wr_hit;
  logic            skctl_wr;
  logic            stimer_wr;
  logic            count_en;
  logic            commit;

  assign skctl_wr  = wr_en && (wr_addr == 4'hF);
  assign stimer_wr = wr_en && (wr_addr == 4'h9) && (state == RUN);

  always_comb begin
    state_next  = state;
    poly_init_L = (state == RUN);
    if (skctl_wr)
      state_next = (wr_data[1:0] != 2'b00) ? RUN : HOLD;
  end

  always_ff @(posedge clk179) begin
    if (init) state <= HOLD;
    else      state <= state_next;
  end

  // Counters only advance while staying in RUN, so entering RUN starts from 0
  // and leaving RUN clears them before the first HOLD cycle.
  assign count_en = (state == RUN) && (state_next == RUN);

  always_ff @(posedge clk179) begin
    if (init || !count_en || stimer_pulse) begin
      cnt64 <= '0;
      cnt15 <= '0;
    end else begin
      cnt64 <= (cnt64 == LAST64) ? '0 : cnt64 + W64'(1);
      cnt15 <= (cnt15 == LAST15) ? '0 : cnt15 + W15'(1);
    end
  end

  assign tick64    = (state == RUN) && (cnt64 == LAST64);
  assign tick15    = (state == RUN) && (cnt15 == LAST15);
  assign tick_main = live[8][0] ? tick15 : tick64;
  assign commit    = (state == RUN) && (tick_main || stimer_wr);

  always_ff @(posedge clk179) begin
    if (init) stimer_pulse <= 1'b0;
    else      stimer_pulse <= stimer_wr;
  end

  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < 9; i++)
      if (wr_en && (wr_addr == 4'(i))) wr_hit[i] = 1'b1;
  end

  // A write on a commit cycle lands after the old pending value is copied,
  // and its flag assignment overrides the clear.
  always_ff @(posedge clk179) begin
    if (init) begin
      pend_flag <= '0;
      for (int unsigned i = 0; i < 9; i++) begin
        live[i] <= '0;
        pend[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 9; i++) begin
        if (commit && pend_flag[i]) begin
          live[i]      <= pend[i];
          pend_flag[i] <= 1'b0;
        end
        if (wr_hit[i]) begin
          pend[i]      <= wr_data;
          pend_flag[i] <= 1'b1;
        end
      end
    end
  end

  assign AUDF1  = live[0];
  assign AUDC1  = live[1];
  assign AUDF2  = live[2];
  assign AUDC2  = live[3];
  assign AUDF3  = live[4];
  assign AUDC3  = live[5];
  assign AUDF4  = live[6];
  assign AUDC4  = live[7];
  assign AUDCTL = live[8];

`ifdef POKEY_AUDIO_CTRL_READBACK_EN
  logic [1:0] skctl;

  always_ff @(posedge clk179) begin
    if (init)          skctl <= 2'b00;
    else if (skctl_wr) skctl <= wr_data[1:0];
  end

  always_ff @(posedge clk179) begin
    if (init) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (rd_addr <= 4'd8)       rd_data <= live[rd_addr];
      else if (rd_addr == 4'hF)  rd_data <= {6'b0, skctl};
      else                       rd_data <= '0;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_en, rd_addr};
  assign rd_data   = '0;
`endif

endmodule
